ntt_stage_scheduler: RTL and testbench
======================================

# ntt_stage_scheduler

Sequences a complete in-place radix-2 NTT or inverse NTT over an N-coefficient dual-port RAM. For every stage and butterfly it generates the read address pair and twiddle (ROM) index, and replays the same address pair to the write port after the butterfly pipeline latency. Between stages it drains the pipeline so the next stage never reads stale data. It sits between the top-level start/done handshake and the RAM, twiddle-ROM and butterfly datapath, and replaces the free-running linear address sweep used for bulk load/unload during transform passes.

## Interface
- N, 256: transform length; power of two, ≥4. LOGN = $clog2(N).
- BFLY_LAT, 4: cycles from rd_en to matching wr_en; covers RAM read, ROM read and butterfly; ≥1.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a transform; sampled only in IDLE.
- inverse  in  1  0 = forward (CT), 1 = inverse (GS); latched with start.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse at completion.
- bfly_inv  out  1  latched mode, drives the datapath CT/GS select.
- stage  out  LOGN bits  current stage index s.
- rd_en  out  1  read-pair valid.
- rd_addr_a, rd_addr_b  out  LOGN each  butterfly operand addresses.
- tw_addr  out  LOGN  twiddle ROM index, valid with rd_en.
- wr_en  out  1  write-back valid.
- wr_addr_a, wr_addr_b  out  LOGN each  write-back addresses.

## Operation
- All outputs are registered; all reset to 0, and state resets to IDLE.
- States:
  - IDLE: on start=1, latch inverse into bfly_inv, clear stage and j, go to ISSUE.
  - ISSUE: one butterfly per cycle, j = 0..N/2-1. After j = N/2-1, go to DRAIN.
  - DRAIN: lasts BFLY_LAT cycles. Then, if stage = LOGN-1, go to DONE; otherwise increment stage, clear j, go to ISSUE.
  - DONE: lasts one cycle, then IDLE.
- Butterfly j of stage s:
  - len: forward N>>(s+1); inverse 1<<s.
  - group = j / len, k = j % len.
  - rd_addr_a = 2·len·group + k; rd_addr_b = rd_addr_a + len.
  - tw_addr: forward (1<<s) + group; inverse (N>>(s+1)) + group.
  - len is a power of two, so division and modulo are shifts and masks. All results fit in LOGN bits with no wrap.
- Write-back: a BFLY_LAT-deep shift line carries {rd_en, rd_addr_a, rd_addr_b} to {wr_en, wr_addr_a, wr_addr_b}.
- start while busy is ignored. inverse is ignored outside the start cycle.
- Reset asserted mid-transform: all state and the delay line clear immediately; no write-back completes after reset.

## Timing
- start sampled high at edge 0: busy=1 and the first rd_en=1 are visible from cycle 1.
- Per stage: N/2 ISSUE cycles with rd_en=1, then BFLY_LAT DRAIN cycles with rd_en=0.
- wr_en at cycle t+BFLY_LAT for each rd_en at cycle t. The last write of a stage lands in that stage's final DRAIN cycle. The next stage's first read is in the following cycle, so write-before-read ordering holds.
- busy is high for exactly LOGN·(N/2+BFLY_LAT) cycles.
- done=1 in the cycle after busy falls; busy=0 in that cycle.
- Defaults: busy in cycles 1..1056, done in cycle 1057.
- A start accepted in the done cycle is ignored. The earliest new start is sampled in the cycle after done.
- stage changes on the edge entering the next ISSUE and holds through DRAIN.

## Structure
- Package ntt_sched_pkg holds:
  - typedef enum state_t {IDLE, ISSUE, DRAIN, DONE};
  - localparam-derivation helpers (LOGN);
  - a function computing {addr_a, addr_b, tw} from (s, j, inverse, N).
- Sub-module ntt_wb_delay: parameterised-depth, parameterised-width shift register with async active-low clear. It is instantiated once for the write-back line.

## Test plan
- Forward, N=8, BFLY_LAT=2:
  - stage 0, j=0 → (0,4), tw 1; j=3 → (3,7), tw 1.
  - stage 1, j=2 → (4,6), tw 3.
  - stage 2, j=3 → (6,7), tw 7.
- Inverse, N=8:
  - stage 0, j=1 → (2,3), tw 5.
  - stage 2, j=0 → (0,4), tw 1.
  - bfly_inv=1 throughout.
- Defaults, one start:
  - busy high for exactly 1056 cycles; done pulses once at cycle 1057.
  - 1024 rd_en and 1024 wr_en cycles.
  - each wr pair equals the rd pair from 4 cycles earlier.
  - no rd_en in any DRAIN cycle.
- Start pulsed at cycles 10 and 500 of a transform, and again in the done cycle → all ignored; exactly one done.
- reset_n low at cycle 300 → all outputs 0 asynchronously; no wr_en after release. A fresh start then completes normally.
- Back-to-back: start in the cycle after done → second transform begins with rd_addr (0, N/2) in the next cycle.

Source files
------------

// File: rtl/ntt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_sched_pkg
// Description : Shared types and helpers for the NTT stage scheduler:
//               FSM state encoding, LOGN derivation and butterfly
//               address / twiddle-index computation.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Address pair and twiddle index of one butterfly, kept at full int width
  typedef struct packed {
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] tw;
  } bfly_addr_t;

  // Address width needed for an n-point transform
  function automatic int calc_logn(input int n);
    return $clog2(n);
  endfunction

  // Butterfly j of stage s. The half-span len is a power of two, so its
  // log2 (l2) turns group/offset division and modulo into shift and mask.
  function automatic bfly_addr_t bfly_addr(input logic [31:0] s,
                                           input logic [31:0] j,
                                           input logic        inv,
                                           input logic [31:0] logn);
    logic [31:0] l2;
    logic [31:0] grp;
    logic [31:0] k;
    logic [31:0] a;
    bfly_addr_t  r;
    l2       = inv ? s : (logn - 32'd1 - s);
    grp      = j >> l2;
    k        = j & ((32'd1 << l2) - 32'd1);
    a        = (grp << (l2 + 32'd1)) + k;
    r.addr_a = a;
    r.addr_b = a + (32'd1 << l2);
    r.tw     = (inv ? (32'd1 << (logn - 32'd1 - s)) : (32'd1 << s)) + grp;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_wb_delay.sv
`default_nettype none
// ============================================================================
// Module      : ntt_wb_delay
// Description : Fixed-depth shift line with asynchronous active-low clear.
//               Replays the read-side valid and address pair to the write
//               port after the butterfly pipeline latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_wb_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift one slot per cycle; clearing on reset discards any in-flight write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ntt_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ntt_stage_scheduler
// Description : Sequences an in-place radix-2 forward (CT) or inverse (GS)
//               NTT: per-stage butterfly read addresses and twiddle index,
//               delayed write-back addresses, and a pipeline drain between
//               stages so no stage reads data still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_stage_scheduler
  import ntt_sched_pkg::*;
#(
  parameter  int N        = 256,
  parameter  int BFLY_LAT = 4,
  localparam int LOGN     = calc_logn(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            inverse,
  output logic            busy,
  output logic            done,
  output logic            bfly_inv,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int              c_JW     = LOGN - 1;
  localparam int              c_CW     = $clog2(BFLY_LAT + 1);
  localparam int              c_WB_W   = 2 * LOGN + 1;
  localparam logic [c_JW-1:0] c_J_LAST = c_JW'(N / 2 - 1);
  localparam logic [c_CW-1:0] c_D_LAST = c_CW'(BFLY_LAT - 1);
  localparam logic [LOGN-1:0] c_S_LAST = LOGN'(LOGN - 1);

  state_t            r_state, w_state_nxt;
  logic [LOGN-1:0]   r_stage, w_stage_nxt;
  logic [c_JW-1:0]   r_j,     w_j_nxt;
  logic [c_CW-1:0]   r_dcnt,  w_dcnt_nxt;
  logic              r_inv,   w_inv_nxt;
  logic              r_busy, r_done, r_rd_en;
  logic [LOGN-1:0]   r_rd_a, r_rd_b, r_tw;
  bfly_addr_t        w_bfly;
  logic [c_WB_W-1:0] w_wb;

  // Next-state sequencing; outputs are registered from the next-state view so
  // the first read appears in the cycle right after start is accepted
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_j_nxt     = r_j;
    w_dcnt_nxt  = r_dcnt;
    w_inv_nxt   = r_inv;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
          w_inv_nxt   = inverse;
          w_stage_nxt = '0;
          w_j_nxt     = '0;
        end
      end
      ISSUE: begin
        if (r_j == c_J_LAST) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = '0;
        end else begin
          w_j_nxt = r_j + 1'b1;
        end
      end
      DRAIN: begin
        if (r_dcnt == c_D_LAST) begin
          if (r_stage == c_S_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ISSUE;
            w_stage_nxt = r_stage + 1'b1;
            w_j_nxt     = '0;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_bfly = bfly_addr(32'(w_stage_nxt), 32'(w_j_nxt), w_inv_nxt, 32'(LOGN));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_j     <= '0;
      r_dcnt  <= '0;
      r_inv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_j     <= w_j_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_inv   <= w_inv_nxt;
      r_busy  <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == DONE);
      r_rd_en <= (w_state_nxt == ISSUE);
      r_rd_a  <= w_bfly.addr_a[LOGN-1:0];
      r_rd_b  <= w_bfly.addr_b[LOGN-1:0];
      r_tw    <= w_bfly.tw[LOGN-1:0];
    end
  end

  ntt_wb_delay #(
    .DEPTH (BFLY_LAT),
    .WIDTH (c_WB_W)
  ) u_wb_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .i_data  ({r_rd_en, r_rd_a, r_rd_b}),
    .o_data  (w_wb)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = w_wb;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bfly_inv  = r_inv;
  assign stage     = r_stage;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign tw_addr   = r_tw;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ntt_stage_scheduler
// Description : Scoreboard bench: start acceptance pushes every expected
//               read/write event into queues; a negedge monitor pops and
//               compares. A second small instance checks N=8 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_scheduler;

  localparam int N = 256, L = 4, LOGN = 8;

  typedef struct {
    int cyc; int a; int b; int tw; int st; int inv;
  } ev_t;

  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, inverse = 1'b0;
  logic busy, done, bfly_inv, rd_en, wr_en;
  logic [LOGN-1:0] stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

  logic start8 = 1'b0, inverse8 = 1'b0;
  logic busy8, done8, bfly_inv8, rd_en8, wr_en8;
  logic [2:0] stage8, rd_a8, rd_b8, tw8, wr_a8, wr_b8;

  int   total = 0, bad = 0, cyc = 0;
  int   busy_lo = 1, busy_hi = 0, exp_done = -10;
  bit   mon_on = 1'b0;
  ev_t  rdq[$], wrq[$];

  ntt_stage_scheduler #(.N(N), .BFLY_LAT(L)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .bfly_inv(bfly_inv), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b));

  ntt_stage_scheduler #(.N(8), .BFLY_LAT(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .inverse(inverse8),
    .busy(busy8), .done(done8), .bfly_inv(bfly_inv8), .stage(stage8),
    .rd_en(rd_en8), .rd_addr_a(rd_a8), .rd_addr_b(rd_b8),
    .tw_addr(tw8), .wr_en(wr_en8), .wr_addr_a(wr_a8), .wr_addr_b(wr_b8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: whole transform from the arithmetic definition
  task automatic accept(input int cs, input int inv);
    ev_t e;
    for (int s = 0; s < LOGN; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        int len, grp, k;
        len   = inv ? (1 << s) : (N >> (s + 1));
        grp   = j / len;
        k     = j % len;
        e.cyc = cs + s * (N / 2 + L) + j;
        e.a   = 2 * len * grp + k;
        e.b   = e.a + len;
        e.tw  = inv ? ((N >> (s + 1)) + grp) : ((1 << s) + grp);
        e.st  = s;
        e.inv = inv;
        rdq.push_back(e);
        e.cyc = e.cyc + L;
        wrq.push_back(e);
      end
    end
    busy_lo  = cs;
    busy_hi  = cs + LOGN * (N / 2 + L) - 1;
    exp_done = busy_hi + 1;
  endtask

  // Raise start for one sampling edge; the model decides acceptance
  task automatic drive_start(input int inv);
    int c;
    start = 1'b1; inverse = inv[0];
    @(posedge clk); #1;
    c = cyc;
    if (reset_n && (c - 1 > exp_done)) accept(c, inv);
    start = 1'b0; inverse = 1'($urandom % 2);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);  chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_stage"}, stage, 0);  chk({tag, "_inv"}, bfly_inv, 0);
    chk({tag, "_rd_a"}, rd_addr_a, 0); chk({tag, "_rd_b"}, rd_addr_b, 0);
    chk({tag, "_tw"}, tw_addr, 0);   chk({tag, "_wr_a"}, wr_addr_a, 0);
    chk({tag, "_wr_b"}, wr_addr_b, 0);
  endtask

  // Monitor: compare every output cycle against the queued expectations
  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        e = rdq.pop_front();
        chk("rd_en", rd_en, 1);
        chk("rd_addr_a", rd_addr_a, e.a);
        chk("rd_addr_b", rd_addr_b, e.b);
        chk("tw_addr", tw_addr, e.tw);
        chk("stage", stage, e.st);
        chk("bfly_inv", bfly_inv, e.inv);
      end else begin
        chk("rd_en_idle", rd_en, 0);
      end
      if (wrq.size() > 0 && wrq[0].cyc == cyc) begin
        e = wrq.pop_front();
        chk("wr_en", wr_en, 1);
        chk("wr_addr_a", wr_addr_a, e.a);
        chk("wr_addr_b", wr_addr_b, e.b);
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      chk("done", done, (cyc == exp_done) ? 1 : 0);
    end
  end

  // Small instance: collect all reads of one transform and test known points
  task automatic run8(input int inv);
    int qa[$], qb[$], qt[$];
    int ninv = 0, ndone = 0;
    start8 = 1'b1; inverse8 = inv[0];
    @(negedge clk);
    start8 = 1'b0; inverse8 = ~inv[0];
    for (int i = 0; i < 30; i++) begin
      if (rd_en8) begin
        qa.push_back(int'(rd_a8)); qb.push_back(int'(rd_b8));
        qt.push_back(int'(tw8));
        if (bfly_inv8 != inv[0]) ninv++;
      end
      if (done8) ndone++;
      @(negedge clk);
    end
    chk("n8_rd_count", qa.size(), 12);
    chk("n8_done_count", ndone, 1);
    chk("n8_inv_mismatch", ninv, 0);
    if (qa.size() == 12) begin
      if (inv == 0) begin
        chk("n8f_s0j0_a", qa[0], 0);  chk("n8f_s0j0_b", qb[0], 4);  chk("n8f_s0j0_tw", qt[0], 1);
        chk("n8f_s0j3_a", qa[3], 3);  chk("n8f_s0j3_b", qb[3], 7);  chk("n8f_s0j3_tw", qt[3], 1);
        chk("n8f_s1j2_a", qa[6], 4);  chk("n8f_s1j2_b", qb[6], 6);  chk("n8f_s1j2_tw", qt[6], 3);
        chk("n8f_s2j3_a", qa[11], 6); chk("n8f_s2j3_b", qb[11], 7); chk("n8f_s2j3_tw", qt[11], 7);
      end else begin
        chk("n8i_s0j1_a", qa[1], 2);  chk("n8i_s0j1_b", qb[1], 3);  chk("n8i_s0j1_tw", qt[1], 5);
        chk("n8i_s2j0_a", qa[8], 0);  chk("n8i_s2j0_b", qb[8], 4);  chk("n8i_s2j0_tw", qt[8], 1);
      end
    end
  endtask

  initial begin
    int c0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    mon_on  = 1'b1;
    @(negedge clk);

    run8(0);
    run8(1);

    // Forward transform with ignored starts mid-run and in the done cycle
    drive_start(0);
    c0 = busy_lo;
    wait_cyc(c0 + 9);   drive_start(1);
    wait_cyc(c0 + 499); drive_start(1);
    wait_cyc(exp_done); drive_start(1);
    // Back-to-back: start held in the cycle after done is accepted
    drive_start(int'($urandom % 2));
    chk("b2b_first_rd_en", rd_en, 1);
    chk("b2b_first_rd_a", rd_addr_a, 0);
    chk("b2b_first_rd_b", rd_addr_b, N / 2);
    c0 = busy_lo;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(c0 + int'($urandom_range(20, 1000)));
      drive_start(int'($urandom % 2));
    end
    wait_cyc(exp_done + 1);

    // Asynchronous reset in the middle of a transform
    drive_start(int'($urandom % 2));
    wait_cyc(busy_lo + 299);
    #2 reset_n = 1'b0;
    rdq.delete(); wrq.delete();
    busy_lo = 1; busy_hi = 0; exp_done = -10;
    #1 chk_all_zero("async_rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Fresh transform after reset completes normally
    drive_start(int'($urandom % 2));
    wait_cyc(exp_done + 2);
    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
